uart_tx_ctrl: RTL and testbench
===============================

Name: uart_tx_ctrl

Overview:
Frame sequencer for the UART transmit path. Accepts one parallel data word per frame with a valid strobe, then serialises it as start bit, DATA_WIDTH data bits LSB-first, an optional parity bit and a stop bit on a single line. Contains the frame FSM, bit-period prescaler, bit counter, shift register and parity generation. Sits between the data source and the TX pin.

Parameters:
DATA_WIDTH, 8, data bits per frame (legal range 5..9)
CLKS_PER_BIT, 1, clk cycles per serial bit period (>=1; 1 = clk is the bit clock)

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  asynchronous active-low reset
P_DATA  input  DATA_WIDTH  parallel word to transmit
Data_valid  input  1  request strobe; sampled only while busy=0
PAR_EN  input  1  1 = insert parity bit; latched at acceptance
PAR_TYP  input  1  0 = even parity, 1 = odd parity; latched at acceptance
TX_OUT  output  1  serial line, registered, idle high
busy  output  1  registered; 1 from acceptance through the end of the stop bit

Behaviour:
- Reset (rst=0, async): state=IDLE, TX_OUT=1, busy=0, bit counter=0, prescaler=0, shift reg=0, latched parity bit=0, latched PAR_EN=0. Takes effect immediately mid-frame; the frame is abandoned, with no partial completion after release.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX_OUT=1, busy=0. At an edge with Data_valid=1: latch P_DATA into the shift reg; latch PAR_EN; latch par_bit = ^P_DATA if PAR_TYP=0, ~^P_DATA if PAR_TYP=1. Go to START. TX_OUT=0 and busy=1 are visible after that same edge.
- Each bit is held exactly CLKS_PER_BIT cycles. The prescaler counts 0..CLKS_PER_BIT-1 and advances the FSM on the terminal count.
- START -> DATA: TX_OUT=shift[0]. On each bit period end, shift right and increment the bit counter.
- DATA: after DATA_WIDTH bits, go to PARITY if latched PAR_EN=1, else STOP.
- PARITY: TX_OUT=latched par_bit for one bit period, then STOP.
- STOP: TX_OUT=1 for one bit period, then IDLE. busy=0 after that edge.
- Timing: acceptance at edge k; with C=CLKS_PER_BIT, W=DATA_WIDTH, P=PAR_EN:
  - data bit i starts at edge k+C(1+i)
  - parity bit starts at edge k+C(1+W)
  - stop bit starts at edge k+C(1+W+P)
  - IDLE at edge k+C(2+W+P)
- Frame length is (2+W+P)*C cycles. The earliest next acceptance is the following edge (minimum 1 idle cycle between frames).
- Data_valid while busy=1 is ignored and not queued. Changes to P_DATA, PAR_EN or PAR_TYP mid-frame have no effect on the current frame.
- Data_valid held high continuously: a new frame starts on every first IDLE cycle.
- Bit counter width: clog2(DATA_WIDTH+1). Prescaler width: clog2(CLKS_PER_BIT), minimum 1. No wrap beyond terminal values.
- TX_OUT is glitch-free: it comes directly from a flop and never passes through combinational logic to the port.

Test Plan:
1. Reset then idle: rst low 3 cycles, release, Data_valid=0 for 20 cycles -> TX_OUT=1, busy=0 throughout.
2. C=1, W=8, P_DATA=8'hA5, PAR_EN=1, PAR_TYP=0 pulsed 1 cycle -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1 (start, LSB-first data, even parity 0, stop); busy high 11 cycles, then 0.
3. P_DATA=8'h01, PAR_EN=1, PAR_TYP=1 -> parity bit 0; PAR_EN=0 with P_DATA=8'hFF -> 10-bit frame 0,1×8,1 and busy high 10 cycles.
4. Data_valid held high with P_DATA=8'h3C changing to 8'hC3 mid-frame -> first frame carries 8'h3C; second frame starts after exactly 1 idle cycle and carries the value present at its acceptance edge.
5. CLKS_PER_BIT=4, P_DATA=8'h55, PAR_EN=0 -> each bit held 4 cycles; total busy time 40 cycles.
6. Assert rst during data bit 3 -> TX_OUT=1 and busy=0 immediately (async); after release, no residual bits. A new Data_valid produces a clean full frame.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART frame sequencer (start, LSB-first data, optional parity, stop)
module uart_tx_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  busy
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam int PW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [PW-1:0] pre, pre_n;
  logic [DATA_WIDTH-1:0] shift, shift_n;
  logic par_bit, par_bit_n, par_en, par_en_n, tx_n, busy_n, tick;
  assign tick = pre == PW'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      pre     <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
      par_en  <= 1'b0;
      TX_OUT  <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      pre     <= pre_n;
      shift   <= shift_n;
      par_bit <= par_bit_n;
      par_en  <= par_en_n;
      TX_OUT  <= tx_n;
      busy    <= busy_n;
    end
  end
  // TX_OUT is computed one cycle ahead so the port is driven straight from a flop
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    pre_n     = (state == IDLE || tick) ? '0 : pre + PW'(1);
    shift_n   = shift;
    par_bit_n = par_bit;
    par_en_n  = par_en;
    tx_n      = TX_OUT;
    busy_n    = busy;
    case (state)
      IDLE: begin
        tx_n   = ~Data_valid;
        busy_n = Data_valid;
        if (Data_valid) begin
          state_n   = START;
          shift_n   = P_DATA;
          par_en_n  = PAR_EN;
          par_bit_n = PAR_TYP ? ~^P_DATA : ^P_DATA;
        end
      end
      START: if (tick) begin
        state_n = DATA;
        tx_n    = shift[0];
        shift_n = shift >> 1;
        cnt_n   = CW'(1);
      end
      DATA: if (tick) begin
        if (cnt == CW'(DATA_WIDTH)) begin
          state_n = par_en ? PARITY : STOP;
          tx_n    = par_en ? par_bit : 1'b1;
          cnt_n   = '0;
        end else begin
          tx_n    = shift[0];
          shift_n = shift >> 1;
          cnt_n   = cnt + CW'(1);
        end
      end
      PARITY: if (tick) begin
        state_n = STOP;
        tx_n    = 1'b1;
      end
      STOP: if (tick) begin
        state_n = IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: randomized frame checks of uart_tx_ctrl against a bit-list reference model
module tb_uart_tx_ctrl;
  logic clk = 1'b0, rst = 1'b0;
  logic [7:0] P_DATA = 8'h00;
  logic PAR_EN = 1'b0, PAR_TYP = 1'b0, dv1 = 1'b0, dv4 = 1'b0;
  logic tx1, b1, tx4, b4;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  uart_tx_ctrl #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .P_DATA(P_DATA), .Data_valid(dv1), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .TX_OUT(tx1), .busy(b1));
  uart_tx_ctrl #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst), .P_DATA(P_DATA), .Data_valid(dv4), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .TX_OUT(tx4), .busy(b4));

  task automatic check_idle(input int n, input string name);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      checks++;
      if ({tx1, b1, tx4, b4} !== 4'b1010) begin
        errors++;
        $display("FAIL %s cycle %0d: tx1/b1/tx4/b4 got %b%b%b%b exp 1010", name, j, tx1, b1, tx4, b4);
      end
    end
  endtask

  // Expected line: list of bits, each held c cycles, starting at the acceptance edge
  task automatic frame(input int c, input logic [7:0] d, input logic pe, input logic pt,
                       input bit keep, input logic [7:0] mid);
    logic exp[$];
    logic txv, bsv;
    exp.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp.push_back(d[i]);
    if (pe) exp.push_back((($countones(d) % 2) == 1) ^ pt);
    exp.push_back(1'b1);
    @(posedge clk);
    for (int j = 0; j < exp.size() * c; j++) begin
      @(negedge clk);
      if (j == 0 && !keep) begin dv1 = 1'b0; dv4 = 1'b0; end
      if (j == 2) begin
        P_DATA = mid;
        if (!keep) begin PAR_EN = ~pe; PAR_TYP = ~pt; end
      end
      txv = c == 1 ? tx1 : tx4;
      bsv = c == 1 ? b1 : b4;
      checks++;
      if (txv !== exp[j / c]) begin
        errors++;
        $display("FAIL frame_tx c=%0d d=%h pe=%b pt=%b cycle %0d: got %b exp %b", c, d, pe, pt, j, txv, exp[j / c]);
      end
      checks++;
      if (bsv !== 1'b1) begin
        errors++;
        $display("FAIL frame_busy c=%0d d=%h cycle %0d: got %b exp 1", c, d, j, bsv);
      end
    end
    @(negedge clk);
    txv = c == 1 ? tx1 : tx4;
    bsv = c == 1 ? b1 : b4;
    checks++;
    if ({txv, bsv} !== 2'b10) begin
      errors++;
      $display("FAIL frame_end c=%0d d=%h: tx/busy got %b%b exp 10", c, d, txv, bsv);
    end
  endtask

  task automatic send(input int c, input logic [7:0] d, input logic pe, input logic pt);
    @(negedge clk);
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt;
    if (c == 1) dv1 = 1'b1; else dv4 = 1'b1;
    frame(c, d, pe, pt, 1'b0, ~d);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx1, b1, tx4, b4} !== 4'b1010) begin
      errors++;
      $display("FAIL reset_hold: got %b%b%b%b exp 1010", tx1, b1, tx4, b4);
    end
    rst = 1'b1;
    check_idle(20, "reset_idle");
  endtask

  task automatic test_known_frames;
    send(1, 8'hA5, 1'b1, 1'b0);
    send(1, 8'h01, 1'b1, 1'b1);
    send(1, 8'hFF, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    P_DATA = 8'h3C; PAR_EN = 1'b1; PAR_TYP = 1'b0; dv1 = 1'b1;
    frame(1, 8'h3C, 1'b1, 1'b0, 1'b1, 8'hC3);
    frame(1, 8'hC3, 1'b1, 1'b0, 1'b0, 8'hC3);
  endtask

  task automatic test_slow_clock;
    send(4, 8'h55, 1'b0, 1'b0);
    send(4, 8'h96, 1'b1, 1'b1);
  endtask

  task automatic test_random;
    for (int n = 0; n < 24; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(($urandom_range(0, 1) == 0) ? 1 : 4, 8'($urandom), 1'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_reset_mid_frame;
    @(negedge clk);
    P_DATA = 8'h5D; PAR_EN = 1'b1; PAR_TYP = 1'b0; dv4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dv4 = 1'b0;
    repeat (16) @(negedge clk);
    checks++;
    if ({tx4, b4} !== 2'b11) begin
      errors++;
      $display("FAIL mid_bit3: tx/busy got %b%b exp 11", tx4, b4);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({tx4, b4} !== 2'b10) begin
      errors++;
      $display("FAIL async_reset: tx/busy got %b%b exp 10", tx4, b4);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    check_idle(45, "post_reset_idle");
    send(4, 8'h5D, 1'b1, 1'b0);
    send(1, 8'hE7, 1'b1, 1'b1);
  endtask

  initial begin
    test_reset;
    test_known_frames;
    test_back_to_back;
    test_slow_clock;
    test_random;
    test_reset_mid_frame;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
